// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings,
// FSM state encoding and the request legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic is_illegal_f3(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) begin
            bad = (funct3 >= 3'b011);
        end else begin
            bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational data shaping: sign/zero extension of loaded words and
// merging of sub-word store data into the old memory word.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    always_comb begin
        load_data_o = raw_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_BU:   load_data_o = {24'd0, raw_i[7:0]};
            F3_H:    load_data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_HU:   load_data_o = {16'd0, raw_i[15:0]};
            default: load_data_o = raw_i;
        endcase
    end

    always_comb begin
        merged_o = wdata_i;
        case (funct3_i)
            F3_B:    merged_o = {raw_i[31:8], wdata_i[7:0]};
            F3_H:    merged_o = {raw_i[31:16], wdata_i[15:0]};
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// RV32I load/store unit in front of a word-wide byte-addressed memory;
// sub-word stores are done as a read cycle followed by a merged write.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int  MEMSIZE = 'h400,
    parameter int  DWIDTH  = 32,
    localparam int WIDTH   = $clog2(MEMSIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    // Request/response handshakes: a transfer happens on a rising edge where
    // valid && ready; the sender holds valid and its payload until then.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    if (DWIDTH != 32) begin : g_bad_dwidth
        $error("lsu_rmw supports only DWIDTH=32");
    end

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [WIDTH-1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_bad;
    logic [31:0]       ext_load;
    logic [31:0]       ext_merged;
    logic              en_c, wen_c;
    logic [WIDTH-1:0]  addr_c;
    logic [31:0]       wdata_c;

    assign req_ready = (state_q == IDLE) && reset_n;
    assign accept    = req_valid && req_ready;
    assign req_bad   = is_illegal_f3(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    lsu_extend u_extend (
        .funct3_i    (funct3_q),
        .raw_i       (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (ext_load),
        .merged_o    (ext_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        en_c    = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        wdata_c = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = 32'd0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                en_c    = 1'b1;
                addr_c  = addr_q;
                rdata_d = ext_load;
                state_d = RESP;
            end
            STORE: begin
                en_c    = 1'b1;
                wen_c   = 1'b1;
                addr_c  = addr_q;
                wdata_c = wdata_q;
                state_d = RESP;
            end
            RMW_RD: begin
                en_c    = 1'b1;
                addr_c  = addr_q;
                merge_d = ext_merged;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                en_c    = 1'b1;
                wen_c   = 1'b1;
                addr_c  = addr_q;
                wdata_c = merge_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything is gated by reset_n so a reset mid-write never touches memory.
    assign mem_en     = en_c && reset_n;
    assign mem_wen    = wen_c && reset_n;
    assign mem_addr   = reset_n ? addr_c : '0;
    assign mem_wdata  = reset_n ? wdata_c : 32'd0;
    assign resp_valid = (state_q == RESP) && reset_n;
    assign resp_rdata = reset_n ? rdata_q : 32'd0;
    assign resp_err   = err_q && reset_n;
    assign dbg_state  = state_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw driving a byte-array memory model that is
// preloaded with 0xDEADBEEF at 0x10.
module tb_lsu_rmw;
    import lsu_pkg::*;

    localparam int MEMSIZE = 'h400;
    localparam int WIDTH   = 10;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [WIDTH-1:0]  req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_wen;
    logic [WIDTH-1:0]  mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    lsu_rmw #(.MEMSIZE(MEMSIZE), .DWIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // memory model: 4 bytes little-endian, addresses wrap modulo MEMSIZE
    logic [7:0] mem [0:MEMSIZE-1];

    assign mem_rdata = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                        mem[mem_addr + 10'd1], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_en && mem_wen) begin
            mem[mem_addr]         <= mem_wdata[7:0];
            mem[mem_addr + 10'd1] <= mem_wdata[15:8];
            mem[mem_addr + 10'd2] <= mem_wdata[23:16];
            mem[mem_addr + 10'd3] <= mem_wdata[31:24];
        end
    end

    function automatic logic [31:0] mem_word(input logic [WIDTH-1:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    // scoreboard helper
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              we;
        logic [2:0]        f3;
        logic [WIDTH-1:0]  addr;
        logic [31:0]       wdata;
        logic [31:0]       exp_rdata;
        logic              exp_err;
        int                lat;
        logic              chk_wd;
        logic [31:0]       exp_wd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [WIDTH-1:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int lat, input logic chk_wd,
                                input logic [31:0] exp_wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
        v.chk_wd = chk_wd; v.exp_wd = exp_wd;
        return v;
    endfunction

    // driver: called at a negedge; waits for ready, issues, checks response
    task automatic run_vec(input vec_t v, input string name);
        int   guard;
        int   cyc;
        logic got;
        logic saw_en;
        logic saw_wen;
        logic [31:0] wd_seen;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        cyc = 1; got = 1'b0; saw_en = 1'b0; saw_wen = 1'b0; wd_seen = 32'd0;
        while (cyc <= 10) begin
            #1;
            if (mem_en) saw_en = 1'b1;
            if (mem_en && mem_wen) begin
                saw_wen = 1'b1;
                wd_seen = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({name, "_valid"}, {31'd0, got}, 32'd1);
        chk({name, "_lat"}, cyc, v.lat);
        chk({name, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({name, "_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
        if (v.exp_err) chk({name, "_no_mem"}, {31'd0, saw_en}, 32'd0);
        if (v.chk_wd) begin
            chk({name, "_wen"}, {31'd0, saw_wen}, 32'd1);
            chk({name, "_wdata"}, wd_seen, v.exp_wd);
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({name, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({name, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({name, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
        chk({name, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    vec_t vecs [$];

    initial begin
        int   guard;
        logic seen;
        for (int i = 0; i < MEMSIZE; i++) mem[i] = 8'h00;
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = 32'd0; resp_ready = 1'b1;

        vecs.push_back(mk(0, F3_B,   10'h010, 32'd0,        32'hFFFFFFEF, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_BU,  10'h010, 32'd0,        32'h000000EF, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_H,   10'h010, 32'd0,        32'hFFFFBEEF, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_HU,  10'h010, 32'd0,        32'h0000BEEF, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_W,   10'h010, 32'd0,        32'hDEADBEEF, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_B,   10'h013, 32'd0,        32'hFFFFFFDE, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_HU,  10'h012, 32'd0,        32'h0000DEAD, 0, 2, 0, 32'd0));
        vecs.push_back(mk(1, F3_B,   10'h010, 32'h12345678, 32'h00000000, 0, 3, 1, 32'hDEADBE78));
        vecs.push_back(mk(0, F3_W,   10'h010, 32'd0,        32'hDEADBE78, 0, 2, 0, 32'd0));
        vecs.push_back(mk(1, F3_H,   10'h011, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 32'd0));
        vecs.push_back(mk(0, F3_W,   10'h012, 32'd0,        32'h00000000, 1, 1, 0, 32'd0));
        vecs.push_back(mk(0, 3'b011, 10'h010, 32'd0,        32'h00000000, 1, 1, 0, 32'd0));
        vecs.push_back(mk(1, 3'b100, 10'h010, 32'h11111111, 32'h00000000, 1, 1, 0, 32'd0));
        vecs.push_back(mk(0, 3'b110, 10'h010, 32'd0,        32'h00000000, 1, 1, 0, 32'd0));
        vecs.push_back(mk(0, F3_W,   10'h010, 32'd0,        32'hDEADBE78, 0, 2, 0, 32'd0));
        vecs.push_back(mk(1, F3_H,   10'h012, 32'hAAAA5555, 32'h00000000, 0, 3, 1, 32'h00005555));
        vecs.push_back(mk(0, F3_W,   10'h010, 32'd0,        32'h5555BE78, 0, 2, 0, 32'd0));
        vecs.push_back(mk(1, F3_B,   10'h3FF, 32'hABCDEF77, 32'h00000000, 0, 3, 1, 32'h00000077));
        vecs.push_back(mk(0, F3_BU,  10'h3FF, 32'd0,        32'h00000077, 0, 2, 0, 32'd0));
        vecs.push_back(mk(0, F3_B,   10'h3FF, 32'd0,        32'h00000077, 0, 2, 0, 32'd0));
        vecs.push_back(mk(1, F3_W,   10'h3FC, 32'h11223344, 32'h00000000, 0, 2, 1, 32'h11223344));
        vecs.push_back(mk(0, F3_W,   10'h3FC, 32'd0,        32'h11223344, 0, 2, 0, 32'd0));

        // reset state
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk_all_zero("in_reset");
        req_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
        chk("post_reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // SW with response backpressure
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 10'h020; req_wdata = 32'hCAFEF00D; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_first_valid", {31'd0, resp_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_rdata", k), resp_rdata, 32'd0);
            chk($sformatf("bp_hold%0d_err", k), {31'd0, resp_err}, 32'd0);
            chk($sformatf("bp_hold%0d_ready", k), {31'd0, req_ready}, 32'd0);
        end
        chk("bp_mem_written", mem_word(10'h020), 32'hCAFEF00D);
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        run_vec(mk(0, F3_W, 10'h020, 32'd0, 32'hCAFEF00D, 0, 2, 0, 32'd0), "bp_next_lw");

        // reset while the SB write cycle is on the memory port
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 10'h020; req_wdata = 32'h00000099; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rst_rmw_rd_state", {29'd0, dbg_state}, {29'd0, RMW_RD});
        @(negedge clk);
        #1;
        chk("rst_rmw_wr_state", {29'd0, dbg_state}, {29'd0, RMW_WR});
        chk("rst_rmw_wr_wen_before", {31'd0, mem_wen}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_during_wr");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_after_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_after_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_after_rdata", resp_rdata, 32'd0);
        chk("rst_after_err", {31'd0, resp_err}, 32'd0);
        chk("rst_after_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_after_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_after_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_unchanged", mem_word(10'h020), 32'hCAFEF00D);
        seen = 1'b0;
        guard = 0;
        while (guard < 4) begin
            @(negedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
            guard++;
        end
        chk("rst_no_response", {31'd0, seen}, 32'd0);
        run_vec(mk(0, F3_W, 10'h020, 32'd0, 32'hCAFEF00D, 0, 2, 0, 32'd0), "rst_final_lw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store unit sitting directly upstream of the byte-addressable data memory.
- Memory is word-wide (DWIDTH bits, 4 bytes). Reads are combinational. Writes happen on posedge when en&wen and always write all 4 bytes at addr..addr+3.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW from the execute stage.
- Sub-word stores are performed as read-modify-write.
- Loads are sign- or zero-extended before being returned.

Parameters:
- MEMSIZE, 'h400, memory size in bytes (power of two).
- DWIDTH, 32, data width; only 32 is supported (elaboration error otherwise).
- WIDTH, $clog2(MEMSIZE), localparam, address width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  WIDTH  byte address.
- req_wdata  in  32  store data; low bytes are used for B/H.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3.
- mem_en  out  1  memory enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from mem_addr).

Behaviour:
- Clock is clk. Reset is reset_n: synchronous, active-low.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset (reset_n=0 at a posedge): state=IDLE and all response/request registers are cleared.
  - While reset_n is low, every output is 0 (req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_wen, mem_addr, mem_wdata).
  - mem_en is gated by reset_n. A reset during RMW_WR or STORE therefore produces no memory write.
  - A reset during any state abandons the operation; no response is issued.
- req_ready = (state==IDLE) && reset_n. Accept = req_valid && req_ready; all request fields are registered at the accept edge.
- Error check at accept: error = H/HU with addr[0]!=0, W with addr[1:0]!=0, load funct3 in {011,110,111}, or store funct3 >= 011.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No memory access.
- IDLE -> LOAD (load), STORE (SW), RMW_RD (SB/SH), RESP (error).
- LOAD: mem_en=1, mem_wen=0, mem_addr=registered address. mem_rdata is captured and extended, then go to RESP.
  - Extension: B sign-extends bits [7:0], BU zero-extends, H sign-extends [15:0], HU zero-extends, W passes through.
- STORE: mem_en=1, mem_wen=1, mem_wdata=req_wdata; the write occurs at the end of this cycle, then go to RESP.
- RMW_RD: mem_en=1, mem_wen=0. mem_rdata is captured into the merge register, with byte 0 (SB) or bytes 0-1 (SH) replaced by req_wdata low bytes. Go to RMW_WR.
- RMW_WR: mem_en=1, mem_wen=1, mem_wdata=merge register, same address. Go to RESP.
- RESP: resp_valid=1, with resp_rdata and resp_err stable.
  - Stays in RESP until resp_ready=1 at a posedge, then goes to IDLE.
  - resp_ready=1 on the first RESP cycle gives single-cycle completion.
- Outside LOAD/STORE/RMW_*: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Latency, counting accept as cycle 0 with resp_ready held 1:
  - Loads and SW: resp_valid in cycle 2.
  - SB/SH: resp_valid in cycle 3.
  - Errors: resp_valid in cycle 1.
  - Back-to-back throughput: one request per latency+1 cycles.
- Address wrap: mem_addr is passed unchanged. Byte wrap near MEMSIZE-1 (addr+i modulo MEMSIZE) is the memory's behaviour; SB at MEMSIZE-1 is legal.
- req_valid while not ready is ignored; the requester must hold it.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - typedef enum logic [2:0] lsu_state_t.
  - function is_misaligned(funct3, addr[1:0]).
- One sub-module, lsu_extend, is combinational:
  - Inputs funct3 and 32-bit raw word; output extended load data.
  - Also produces the merged store word from old word, new data and funct3.
- lsu_rmw contains the FSM and registers only.

Test Plan:
- Bench wiring: lsu_rmw is connected to the data memory model, which is preloaded with 0xDEADBEEF at 0x10.
- LB at 0x10 -> resp_rdata=0xFFFFFFEF, err=0, resp_valid at cycle 2. LBU at 0x10 -> 0x000000EF. LH at 0x10 -> 0xFFFFBEEF. LHU at 0x10 -> 0x0000BEEF.
- SB 0x12345678 to 0x10 -> one read cycle then one write cycle with mem_wdata=0xDEADBE78, resp at cycle 3. A following LW at 0x10 returns 0xDEADBE78.
- SH at 0x11 -> resp_err=1 at cycle 1, mem_en never asserted, memory unchanged. LW at 0x12 -> resp_err=1. Load funct3=011 -> resp_err=1.
- SW 0xCAFEF00D at 0x20 with resp_ready held 0 for 3 cycles -> resp_valid held with stable data, req_ready=0 throughout. Release -> IDLE, and the next request is accepted the following cycle.
- SB started, reset_n pulled low during the RMW_WR cycle -> mem_en=0 that cycle, memory word unchanged, no response. After release req_ready=1 and all outputs are 0.
